pc_gen: RTL and testbench

Parametrised program-counter generator for the RV32I fetch stage, and the successor to the single-cycle PC register. It computes and holds the fetch PC from four next-PC sources: increment, PC-relative branch/JAL, register-indirect JALR and trap vector. It also supports a fetch stall, registered misaligned-target detection and an optional return-address stack (RAS) that drives a return-prediction output.

---
 rtl/pc_pkg.sv | 6 +
 rtl/pc_ras.sv | 38 +++
 rtl/pc_gen.sv | 63 ++++++
 tb/tb_pc_gen.sv | 117 +++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: next-PC source encoding and shared constants for the fetch PC generator
package pc_pkg;
  typedef enum logic [1:0] {PC_INC = 2'd0, PC_BRANCH = 2'd1, PC_JALR = 2'd2, PC_TRAP = 2'd3} pc_src_t;
  localparam int PC_STEP = 4;
  localparam logic [1:0] MISALIGN_MASK = 2'b10;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; push+pop together replaces the top (ports: clk, rst, push, pop, push_data, top, valid)
module pc_ras #(
  parameter int XLEN = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            valid
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr, tp;
  logic [PW:0] cnt;
  logic repl;
  assign tp = ptr - 1'b1;
  assign valid = cnt != '0;
  assign top = valid ? mem[tp] : '0;
  // an empty stack turns a replace into a plain push
  assign repl = push & pop & valid;
  always_ff @(posedge clk)
    if (push) mem[repl ? tp : ptr] <= push_data;
  // a full push wraps ptr onto the oldest entry while cnt saturates
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push & ~repl) begin
      ptr <= ptr + 1'b1;
      cnt <= cnt == (PW+1)'(RAS_DEPTH) ? cnt : cnt + 1'b1;
    end else if (pop & ~push & valid) begin
      ptr <= tp;
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: RV32I fetch PC generator (inc/branch/jalr/trap, stall, misalign pulse, optional RAS via RAS_EN; ports clk, rst, en, pc_src, imm, rs1, trap_vec, is_call, is_ret -> pc, pc_plus4, misalign, ras_top, ras_valid)
module pc_gen
  import pc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IMM_W = 13,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       pc_src,
  input  logic [IMM_W-1:0] imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  trap_vec,
  input  logic             is_call,
  input  logic             is_ret,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             misalign,
  output logic [XLEN-1:0]  ras_top,
  output logic             ras_valid
);
  pc_src_t src;
  logic [XLEN-1:0] sext, tgt;
  logic bad, trap, acc;
  assign src = pc_src_t'(pc_src);
  assign sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign pc_plus4 = pc + XLEN'(PC_STEP);
  always_comb
    tgt = src == PC_INC    ? pc_plus4 :
          src == PC_BRANCH ? pc + sext :
          src == PC_JALR   ? (rs1 + sext) & ~XLEN'(1) :
                             trap_vec & ~XLEN'(3);
  assign bad = (src == PC_BRANCH || src == PC_JALR) && |(tgt[1:0] & MISALIGN_MASK);
  assign trap = src == PC_TRAP;
  assign acc = en & ~bad;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_VEC;
      misalign <= 1'b0;
    end else begin
      if (trap | acc) pc <= tgt;
      misalign <= en & bad;
    end
`ifdef RAS_EN
  pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst(rst),
    .push(acc & is_call & (src == PC_BRANCH || src == PC_JALR)),
    .pop(acc & is_ret & src == PC_JALR),
    .push_data(pc_plus4),
    .top(ras_top),
    .valid(ras_valid)
  );
`else
  logic unused_link;
  assign unused_link = is_call ^ is_ret;
  assign ras_top = '0;
  assign ras_valid = 1'b0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen
module tb_pc_gen;
  import pc_pkg::*;
`ifdef RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  logic clk = 0, rst = 1, en = 0, is_call = 0, is_ret = 0;
  logic [1:0] pc_src = PC_INC;
  logic [12:0] imm = '0;
  logic [31:0] rs1 = '0, trap_vec = '0;
  logic [31:0] pc, pc_plus4, ras_top;
  logic misalign, ras_valid;
  int cyc = 0, checks = 0, passed = 0;
  typedef struct {
    int due;
    logic [31:0] pc;
    logic mis;
    logic [31:0] top;
    logic v;
    string n;
  } exp_t;
  exp_t q[$];

  pc_gen #(.XLEN(32), .IMM_W(13), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_src(pc_src), .imm(imm), .rs1(rs1),
    .trap_vec(trap_vec), .is_call(is_call), .is_ret(is_ret), .pc(pc),
    .pc_plus4(pc_plus4), .misalign(misalign), .ras_top(ras_top), .ras_valid(ras_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  always @(negedge clk)
    if (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check({e.n, ".pc"}, pc, e.pc);
      check({e.n, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
      check({e.n, ".misalign"}, 32'(misalign), 32'(e.mis));
      check({e.n, ".ras_top"}, ras_top, e.top);
      check({e.n, ".ras_valid"}, 32'(ras_valid), 32'(e.v));
    end

  function automatic logic [31:0] rt(input logic [31:0] v);
    return RAS ? v : 32'h0;
  endfunction

  task automatic drv(input string n, input logic e_n, input logic [1:0] s, input logic [12:0] im,
                     input logic [31:0] r, input logic [31:0] tv, input logic c, input logic rr,
                     input logic [31:0] xp, input logic xm, input logic [31:0] xt, input logic xv);
    @(negedge clk);
    en = e_n; pc_src = s; imm = im; rs1 = r; trap_vec = tv; is_call = c; is_ret = rr;
    q.push_back('{cyc + 1, xp, xm, rt(xt), RAS & xv, n});
  endtask

  initial begin
    q.push_back('{0, 32'h100, 1'b0, 32'h0, 1'b0, "reset"});
    repeat (2) @(negedge clk);
    rst = 0;
    drv("inc1", 1, PC_INC, 0, 0, 0, 0, 0, 32'h104, 0, 0, 0);
    drv("inc2", 1, PC_INC, 0, 0, 0, 0, 0, 32'h108, 0, 0, 0);
    drv("inc3", 1, PC_INC, 0, 0, 0, 0, 0, 32'h10C, 0, 0, 0);
    drv("trap200", 1, PC_TRAP, 0, 0, 32'h200, 0, 0, 32'h200, 0, 0, 0);
    drv("br_neg8", 1, PC_BRANCH, 13'h1FF8, 0, 0, 0, 0, 32'h1F8, 0, 0, 0);
    drv("jalr_bit0", 1, PC_JALR, 13'd4, 32'h1001, 0, 0, 0, 32'h1004, 0, 0, 0);
    drv("jalr_mis", 1, PC_JALR, 13'd1, 32'h1005, 0, 0, 0, 32'h1004, 1, 0, 0);
    drv("trap40", 1, PC_TRAP, 0, 0, 32'h40, 0, 0, 32'h40, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv("stall", 0, PC_INC, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0);
    drv("trap_stall", 0, PC_TRAP, 0, 0, 32'h803, 0, 0, 32'h800, 0, 0, 0);
    drv("trap40b", 1, PC_TRAP, 0, 0, 32'h40, 0, 0, 32'h40, 0, 0, 0);
    drv("br_mis", 1, PC_BRANCH, 13'd2, 0, 0, 0, 0, 32'h40, 1, 0, 0);
    drv("inc_after", 1, PC_INC, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0);
    drv("mis_b2b1", 1, PC_BRANCH, 13'd2, 0, 0, 0, 0, 32'h44, 1, 0, 0);
    drv("mis_b2b2", 1, PC_BRANCH, 13'd2, 0, 0, 0, 0, 32'h44, 1, 0, 0);
    drv("mis_clear", 1, PC_INC, 0, 0, 0, 0, 0, 32'h48, 0, 0, 0);
    drv("trap_top", 1, PC_TRAP, 0, 0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
    drv("wrap", 1, PC_INC, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    drv("trap10", 1, PC_TRAP, 0, 0, 32'h10, 1, 0, 32'h10, 0, 0, 0);
    drv("call1", 1, PC_BRANCH, 13'h10, 0, 0, 1, 0, 32'h20, 0, 32'h14, 1);
    drv("call2", 1, PC_BRANCH, 13'h10, 0, 0, 1, 0, 32'h30, 0, 32'h24, 1);
    drv("call3", 1, PC_BRANCH, 13'h10, 0, 0, 1, 0, 32'h40, 0, 32'h34, 1);
    drv("call4", 1, PC_BRANCH, 13'h10, 0, 0, 1, 0, 32'h50, 0, 32'h44, 1);
    drv("call5", 1, PC_BRANCH, 13'h10, 0, 0, 1, 0, 32'h60, 0, 32'h54, 1);
    drv("ret1", 1, PC_JALR, 0, 32'h100, 0, 0, 1, 32'h100, 0, 32'h44, 1);
    drv("ret2", 1, PC_JALR, 0, 32'h100, 0, 0, 1, 32'h100, 0, 32'h34, 1);
    drv("ret3", 1, PC_JALR, 0, 32'h100, 0, 0, 1, 32'h100, 0, 32'h24, 1);
    drv("ret4", 1, PC_JALR, 0, 32'h100, 0, 0, 1, 32'h100, 0, 32'h0, 0);
    drv("ret5", 1, PC_JALR, 0, 32'h100, 0, 0, 1, 32'h100, 0, 32'h0, 0);
    drv("repl_empty", 1, PC_JALR, 0, 32'h200, 0, 1, 1, 32'h200, 0, 32'h104, 1);
    drv("call_stall", 0, PC_BRANCH, 13'h10, 0, 0, 1, 0, 32'h200, 0, 32'h104, 1);
    drv("call_trap", 1, PC_TRAP, 0, 0, 32'h300, 1, 1, 32'h300, 0, 32'h104, 1);
    drv("call_mis", 1, PC_BRANCH, 13'd2, 0, 0, 1, 0, 32'h300, 1, 32'h104, 1);
    drv("repl_full", 1, PC_JALR, 0, 32'h400, 0, 1, 1, 32'h400, 0, 32'h304, 1);
    drv("ret_one", 1, PC_JALR, 0, 32'h400, 0, 0, 1, 32'h400, 0, 32'h0, 0);
    drv("call6", 1, PC_BRANCH, 13'h10, 0, 0, 1, 0, 32'h410, 0, 32'h404, 1);
    @(negedge clk);
    en = 1; pc_src = PC_INC; is_call = 0; is_ret = 0;
    #1 rst = 1;
    #2 rst = 0;
    q.push_back('{cyc + 1, 32'h104, 1'b0, 32'h0, 1'b0, "async_rst"});
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d pending expected %0d", q.size(), 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
